// File: rtl/pipelined_barrel_shifter_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_barrel_shifter_if
// Description : Valid/ready operand and result bus of the pipelined barrel
//               shifter. The slave modport is the shifter's view, the master
//               modport is the producer/consumer view.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    localparam int LOG2W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] din;
    logic [LOG2W-1:0] shamt;
    logic [2:0]       ctrl;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dout;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, din, shamt, ctrl, in_tag, out_ready,
        input  in_ready, out_valid, dout, out_tag
    );

    modport slave (
        input  in_valid, din, shamt, ctrl, in_tag, out_ready,
        output in_ready, out_valid, dout, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_barrel_shifter
// Description : Logarithmic barrel shifter (SLL/SRL/SRA/ROL/ROR/pass) with
//               LEVELS_PER_STAGE shift levels between pipeline registers,
//               whole-pipe stall on output backpressure and a sideband tag.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_barrel_shifter #(
    parameter int WIDTH            = 32,
    parameter int LEVELS_PER_STAGE = 2,
    parameter int TAG_W            = 5
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int LOG2W  = $clog2(WIDTH);
    localparam int STAGES = (LOG2W + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

    logic w_advance;
    logic w_in_ready;

    // One level of the shifter: move by amt in the direction/fill set by mode.
    function automatic logic [WIDTH-1:0] apply_level(
        input logic [WIDTH-1:0] x,
        input logic [2:0]       mode,
        input int               amt
    );
        logic [WIDTH-1:0] r;
        case (mode)
            3'b000:  r = x << amt;
            3'b001:  r = x >> amt;
            3'b011:  r = $signed(x) >>> amt;
            3'b100:  r = (x << amt) | (x >> (WIDTH - amt));
            3'b101:  r = (x >> amt) | (x << (WIDTH - amt));
            default: r = x;
        endcase
        return r;
    endfunction

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        // Shift-amount bits still to be consumed on entry to / exit from stage.
        localparam int IN_W  = LOG2W - s * LEVELS_PER_STAGE;
        localparam int OUT_W = IN_W - LEVELS_PER_STAGE;

        logic                                w_in_valid;
        logic [WIDTH-1:0]                    w_in_data;
        logic [IN_W-1:0]                     w_in_shamt;
        logic [2:0]                          w_in_ctrl;
        logic [TAG_W-1:0]                    w_in_tag;
        logic [LEVELS_PER_STAGE:0][WIDTH-1:0] w_lvl;

        logic             valid_d, valid_q;
        logic [WIDTH-1:0] data_d,  data_q;
        logic [TAG_W-1:0] tag_d,   tag_q;

        if (s == 0) begin : g_src_bus
            assign w_in_valid = bus.in_valid && w_in_ready;
            assign w_in_data  = bus.din;
            assign w_in_shamt = bus.shamt;
            assign w_in_ctrl  = bus.ctrl;
            assign w_in_tag   = bus.in_tag;
        end else begin : g_src_prev
            assign w_in_valid = g_stage[s-1].valid_q;
            assign w_in_data  = g_stage[s-1].data_q;
            assign w_in_shamt = g_stage[s-1].g_carry.shamt_q;
            assign w_in_ctrl  = g_stage[s-1].g_carry.ctrl_q;
            assign w_in_tag   = g_stage[s-1].tag_q;
        end

        // Levels are applied largest first; level K moves by 2^K when shamt[K].
        assign w_lvl[0] = w_in_data;
        for (genvar j = 0; j < LEVELS_PER_STAGE; j++) begin : g_level
            localparam int K = IN_W - 1 - j;
            if (K >= 0) begin : g_shift
                assign w_lvl[j+1] = w_in_shamt[K] ? apply_level(w_lvl[j], w_in_ctrl, 1 << K)
                                                  : w_lvl[j];
            end else begin : g_idle
                assign w_lvl[j+1] = w_lvl[j];
            end
        end

        // Load from the predecessor on advance; the output stage zeroes bubbles.
        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            tag_d   = tag_q;
            if (w_advance) begin
                valid_d = w_in_valid;
                data_d  = w_lvl[LEVELS_PER_STAGE];
                tag_d   = w_in_tag;
                if (s == STAGES - 1 && !w_in_valid) begin
                    data_d = '0;
                    tag_d  = '0;
                end
            end
        end

        // Stage register with synchronous reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                tag_q   <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
                tag_q   <= tag_d;
            end
        end

        if (OUT_W > 0) begin : g_carry
            logic [OUT_W-1:0] shamt_d, shamt_q;
            logic [2:0]       ctrl_d,  ctrl_q;

            // Forward the unconsumed shift bits and mode with the data.
            always_comb begin
                shamt_d = shamt_q;
                ctrl_d  = ctrl_q;
                if (w_advance) begin
                    shamt_d = w_in_shamt[OUT_W-1:0];
                    ctrl_d  = w_in_ctrl;
                end
            end

            // Control sideband register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    shamt_q <= '0;
                    ctrl_q  <= '0;
                end else begin
                    shamt_q <= shamt_d;
                    ctrl_q  <= ctrl_d;
                end
            end
        end
    end

    // A stalled result freezes the entire pipe; bubbles are not squeezed out.
    assign w_advance     = !bus.out_valid || bus.out_ready;
    assign w_in_ready    = w_advance && !rst;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = g_stage[STAGES-1].valid_q;
    assign bus.dout      = g_stage[STAGES-1].data_q;
    assign bus.out_tag   = g_stage[STAGES-1].tag_q;
endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_barrel_shifter
// Description : Self-checking bench for two shifter configurations
//               (32-bit / 2 levels per stage, 16-bit / 1 level per stage)
//               with a bit-wise reference model and per-instance scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_barrel_shifter;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_barrel_shifter_if #(.WIDTH(32), .TAG_W(5)) bus_a ();
    pipelined_barrel_shifter_if #(.WIDTH(16), .TAG_W(5)) bus_b ();

    pipelined_barrel_shifter #(.WIDTH(32), .LEVELS_PER_STAGE(2), .TAG_W(5)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    pipelined_barrel_shifter #(.WIDTH(16), .LEVELS_PER_STAGE(1), .TAG_W(5)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: each output bit picked from its source bit position.
    function automatic logic [31:0] model(input logic [31:0] x, input int w, input int sh,
                                          input logic [2:0] m);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (m)
                3'b000:  r[i] = (i >= sh) ? x[i-sh] : 1'b0;
                3'b001:  r[i] = (i + sh < w) ? x[i+sh] : 1'b0;
                3'b011:  r[i] = (i + sh < w) ? x[i+sh] : x[w-1];
                3'b100:  r[i] = x[(i - sh + w) % w];
                3'b101:  r[i] = x[(i + sh) % w];
                default: r[i] = x[i];
            endcase
        end
        return r;
    endfunction

    // ---------------- scoreboards ----------------
    logic [36:0] qa[$];
    logic [20:0] qb[$];
    logic        a_hold, b_hold;
    logic [31:0] a_pd;
    logic [15:0] b_pd;
    logic [4:0]  a_pt, b_pt;

    always @(negedge clk) begin
        if (rst) begin
            qa.delete();
            a_hold <= 1'b0;
            check("a_in_ready_during_rst", 64'(bus_a.in_ready), 64'd0);
        end else begin
            if (a_hold) begin
                check("a_dout_stable", 64'(bus_a.dout), 64'(a_pd));
                check("a_tag_stable", 64'(bus_a.out_tag), 64'(a_pt));
            end
            if (bus_a.out_valid) begin
                check("a_out_valid_expected", 64'(qa.size() > 0), 64'd1);
                if (bus_a.out_ready && qa.size() > 0) begin
                    check("a_dout", 64'(bus_a.dout), 64'(qa[0][31:0]));
                    check("a_tag", 64'(bus_a.out_tag), 64'(qa[0][36:32]));
                    void'(qa.pop_front());
                end
            end
            a_hold <= bus_a.out_valid && !bus_a.out_ready;
            a_pd   <= bus_a.dout;
            a_pt   <= bus_a.out_tag;
            if (bus_a.in_valid && bus_a.in_ready)
                qa.push_back({bus_a.in_tag, model(bus_a.din, 32, int'(bus_a.shamt), bus_a.ctrl)});
        end
    end

    always @(negedge clk) begin
        logic [31:0] mb;
        if (rst) begin
            qb.delete();
            b_hold <= 1'b0;
            check("b_in_ready_during_rst", 64'(bus_b.in_ready), 64'd0);
        end else begin
            if (b_hold) begin
                check("b_dout_stable", 64'(bus_b.dout), 64'(b_pd));
                check("b_tag_stable", 64'(bus_b.out_tag), 64'(b_pt));
            end
            if (bus_b.out_valid) begin
                check("b_out_valid_expected", 64'(qb.size() > 0), 64'd1);
                if (bus_b.out_ready && qb.size() > 0) begin
                    check("b_dout", 64'(bus_b.dout), 64'(qb[0][15:0]));
                    check("b_tag", 64'(bus_b.out_tag), 64'(qb[0][20:16]));
                    void'(qb.pop_front());
                end
            end
            b_hold <= bus_b.out_valid && !bus_b.out_ready;
            b_pd   <= bus_b.dout;
            b_pt   <= bus_b.out_tag;
            if (bus_b.in_valid && bus_b.in_ready) begin
                mb = model({16'h0, bus_b.din}, 16, int'(bus_b.shamt), bus_b.ctrl);
                qb.push_back({bus_b.in_tag, mb[15:0]});
            end
        end
    end

    // ---------------- drivers (called at posedge + #1) ----------------
    task automatic send_a(input logic [31:0] d, input int sh, input logic [2:0] c,
                          input logic [4:0] t, output int acc);
        bus_a.in_valid = 1'b1;
        bus_a.din      = d;
        bus_a.shamt    = 5'(sh);
        bus_a.ctrl     = c;
        bus_a.in_tag   = t;
        acc = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus_a.in_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) check("a_send_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
    endtask

    task automatic get_a(output logic [31:0] d, output logic [4:0] t, output int at);
        at = -1;
        d  = '0;
        t  = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus_a.out_valid) begin
                d  = bus_a.dout;
                t  = bus_a.out_tag;
                at = cyc;
                break;
            end
        end
        if (at < 0) check("a_get_timeout", 64'd1, 64'd0);
    endtask

    task automatic send_b(input logic [15:0] d, input int sh, input logic [2:0] c,
                          input logic [4:0] t, output int acc);
        bus_b.in_valid = 1'b1;
        bus_b.din      = d;
        bus_b.shamt    = 4'(sh);
        bus_b.ctrl     = c;
        bus_b.in_tag   = t;
        acc = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus_b.in_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) check("b_send_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        bus_b.in_valid = 1'b0;
    endtask

    task automatic get_b(output logic [15:0] d, output logic [4:0] t, output int at);
        at = -1;
        d  = '0;
        t  = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus_b.out_valid) begin
                d  = bus_b.dout;
                t  = bus_b.out_tag;
                at = cyc;
                break;
            end
        end
        if (at < 0) check("b_get_timeout", 64'd1, 64'd0);
    endtask

    task automatic drain(input string name);
        bus_a.in_valid  = 1'b0;
        bus_b.in_valid  = 1'b0;
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (qa.size() == 0 && qb.size() == 0 && !bus_a.out_valid && !bus_b.out_valid) break;
        end
        check({name, "_a_left"}, 64'(qa.size()), 64'd0);
        check({name, "_b_left"}, 64'(qb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] da [4];
        logic [4:0]  ta [4];
        int          at [4];
        int          acc, acc2, when;
        logic [31:0] d32;
        logic [15:0] d16;
        logic [4:0]  tg;

        rst = 1'b1;
        bus_a.in_valid = 1'b0; bus_a.din = '0; bus_a.shamt = '0; bus_a.ctrl = '0;
        bus_a.in_tag = '0; bus_a.out_ready = 1'b1;
        bus_b.in_valid = 1'b0; bus_b.din = '0; bus_b.shamt = '0; bus_b.ctrl = '0;
        bus_b.in_tag = '0; bus_b.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Pin the reference model with hand-computed values.
        check("model_sra32", 64'(model(32'h8000_0001, 32, 4, 3'b011)), 64'hF800_0000);
        check("model_rol32", 64'(model(32'h8000_0001, 32, 1, 3'b100)), 64'h0000_0003);
        check("model_ror32", 64'(model(32'h0000_0001, 32, 1, 3'b101)), 64'h8000_0000);
        check("model_sra16", 64'(model(32'h0000_8000, 16, 15, 3'b011)), 64'h0000_FFFF);

        // Reset state.
        @(negedge clk);
        check("a_rst_out_valid", 64'(bus_a.out_valid), 64'd0);
        check("a_rst_dout", 64'(bus_a.dout), 64'd0);
        check("a_rst_tag", 64'(bus_a.out_tag), 64'd0);
        check("b_rst_out_valid", 64'(bus_b.out_valid), 64'd0);
        check("b_rst_dout", 64'(bus_b.dout), 64'd0);
        @(posedge clk);
        #1;

        // Latency and SRA.
        send_a(32'h8000_0001, 4, 3'b011, 5'd7, acc);
        get_a(d32, tg, when);
        check("a_latency", 64'(when - acc), 64'd3);
        check("a_sra_dout", 64'(d32), 64'hF800_0000);
        check("a_sra_tag", 64'(tg), 64'd7);
        drain("lat");

        // Back-to-back: four consecutive results in issue order.
        fork
            begin
                send_a(32'h0000_00FF, 8, 3'b000, 5'd1, acc);
                send_a(32'h8000_0000, 31, 3'b001, 5'd2, acc);
                send_a(32'h8000_0001, 1, 3'b100, 5'd3, acc);
                send_a(32'h0000_0001, 1, 3'b101, 5'd4, acc);
            end
            begin
                for (int i = 0; i < 4; i++) get_a(da[i], ta[i], at[i]);
            end
        join
        check("b2b_0", 64'({ta[0], da[0]}), 64'({5'd1, 32'h0000_FF00}));
        check("b2b_1", 64'({ta[1], da[1]}), 64'({5'd2, 32'h0000_0001}));
        check("b2b_2", 64'({ta[2], da[2]}), 64'({5'd3, 32'h0000_0003}));
        check("b2b_3", 64'({ta[3], da[3]}), 64'({5'd4, 32'h8000_0000}));
        for (int i = 1; i < 4; i++) check("b2b_consecutive", 64'(at[i] - at[i-1]), 64'd1);
        drain("b2b");

        // Backpressure: fill, stall 5 cycles, release.
        bus_a.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus_a.in_valid = 1'b1;
            bus_a.din      = $urandom;
            bus_a.shamt    = 5'($urandom_range(0, 31));
            bus_a.ctrl     = 3'($urandom_range(0, 7));
            bus_a.in_tag   = 5'(16 + i);
            @(posedge clk);
            #1;
        end
        bus_a.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(bus_a.in_ready), 64'd0);
            check("bp_out_valid", 64'(bus_a.out_valid), 64'd1);
        end
        check("bp_pipe_full", 64'(qa.size()), 64'd3);
        @(posedge clk);
        #1;
        drain("bp");

        // Pass-through code and zero shift.
        send_a(32'h1234_5678, 13, 3'b010, 5'd9, acc);
        get_a(d32, tg, when);
        check("pass_ctrl010", 64'(d32), 64'h1234_5678);
        send_a(32'h1234_5678, 0, 3'b001, 5'd10, acc);
        get_a(d32, tg, when);
        check("zero_shift_srl", 64'(d32), 64'h1234_5678);
        drain("pass");

        // Reset with two operations in flight.
        send_a(32'hDEAD_BEEF, 3, 3'b000, 5'd11, acc);
        send_a(32'hCAFE_F00D, 5, 3'b001, 5'd12, acc2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rst_flush_out_valid", 64'(bus_a.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // Second configuration: latency 4 and 16-bit SRA.
        send_b(16'h8000, 15, 3'b011, 5'd3, acc);
        get_b(d16, tg, when);
        check("b_latency", 64'(when - acc), 64'd4);
        check("b_sra_dout", 64'(d16), 64'hFFFF);
        check("b_sra_tag", 64'(tg), 64'd3);
        send_b(16'h0001, 1, 3'b101, 5'd5, acc);
        get_b(d16, tg, when);
        check("b_ror_dout", 64'(d16), 64'h8000);
        drain("b_dir");

        // Random traffic on the 32-bit instance.
        for (int i = 0; i < 3000; i++) begin
            bus_a.in_valid  = ($urandom_range(0, 3) != 0);
            bus_a.din       = $urandom;
            bus_a.shamt     = 5'($urandom_range(0, 31));
            bus_a.ctrl      = 3'($urandom_range(0, 7));
            bus_a.in_tag    = 5'($urandom_range(0, 31));
            bus_a.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        drain("rand_a");

        // Random traffic on the 16-bit instance.
        for (int i = 0; i < 12000; i++) begin
            bus_b.in_valid  = ($urandom_range(0, 4) != 0);
            bus_b.din       = 16'($urandom);
            bus_b.shamt     = 4'($urandom_range(0, 15));
            bus_b.ctrl      = 3'($urandom_range(0, 7));
            bus_b.in_tag    = 5'($urandom_range(0, 31));
            bus_b.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        drain("rand_b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
